dual_issue_iq: RTL and testbench
================================

DUAL_ISSUE_IQ -- requirements
Module: dual_issue_iq

Interface
REQ-001 Parameter INS_PART_WID, default 4; width of each instruction field (type, dest, src1, src0).
REQ-002 Parameter QUEUE_DEPTH, default 32; entries in the shared circular buffer; power of two, minimum 4.
REQ-003 Parameter AFULL_THRESH, default 28; occupancy at or above which `almost_full` asserts.
REQ-004 Derived PTR_WIDTH = log2(QUEUE_DEPTH); occupancy width is PTR_WIDTH+1.
REQ-005 `clk`  in  1  single clock; all state updates on the rising edge.
REQ-006 `rst_n`  in  1  reset; synchronous and active-low.
REQ-007 `flush`  in  1  discard all queued entries.
REQ-008 `instruction_1`  in  INS_PART_WID*4  older enqueue word: [4W-1:3W] type, [3W-1:2W] dest, [2W-1:W] src1, [W-1:0] src0.
REQ-009 `instruction_val_1`  in  1  `instruction_1` valid.
REQ-010 `instruction_2`  in  INS_PART_WID*4  younger enqueue word; same field layout.
REQ-011 `instruction_val_2`  in  1  `instruction_2` valid.
REQ-012 `enq_ready`  out  1  free entries >= 2.
REQ-013 `inst_1_fetch` / `inst_2_fetch`  in  1 each  consumer takes head / head+1.
REQ-014 `inst_1_valid`, `inst_1_type`, `inst_1_dest`, `inst_1_src0`, `inst_1_src1`  out  1, W, W, W, W  head entry.
REQ-015 `inst_2_valid`, `inst_2_type`, `inst_2_dest`, `inst_2_src0`, `inst_2_src1`  out  1, W, W, W, W  head+1 entry.
REQ-016 `occupancy`  out  PTR_WIDTH+1  entries held.
REQ-017 `empty`, `almost_full`, `overflow`  out  1 each  status flags; `overflow` is sticky.

Function
REQ-018 Single shared FIFO; program order is preserved across both enqueue and both dequeue lanes.
REQ-019 Enqueue is accepted only when `enq_ready`=1; `enq_ready` is evaluated from current-cycle occupancy, with no credit for a same-cycle dequeue.
REQ-020 Both valids set: `instruction_1` is written at wr_ptr, `instruction_2` at wr_ptr+1, and wr_ptr advances by 2.
REQ-021 Exactly one valid set: that word is written at wr_ptr and wr_ptr advances by 1 (compaction; no holes).
REQ-022 Any valid while `enq_ready`=0: the words are dropped, no state changes, and `overflow` is set until reset.
REQ-023 Outputs are show-ahead, combinational from registered storage: `inst_1_*` is entry[rd_ptr] and `inst_2_*` is entry[rd_ptr+1].
REQ-024 `inst_1_valid` = occupancy>=1; `inst_2_valid` = occupancy>=2.
REQ-025 Field outputs hold the stored data even when the matching valid is 0; the bench checks fields only when valid=1.
REQ-026 Dequeue count:
- 2 when `inst_1_fetch`&`inst_1_valid`&`inst_2_fetch`&`inst_2_valid`;
- 1 when `inst_1_fetch`&`inst_1_valid` otherwise;
- 0 in all other cases.
REQ-027 `inst_2_fetch` without `inst_1_fetch` is ignored (in-order issue).
REQ-028 Same-cycle enqueue and dequeue: occupancy_next = occupancy + n_enq - n_dequeue; rd_ptr advances by n_dequeue.
REQ-029 Pointers wrap modulo QUEUE_DEPTH; a two-word enqueue or dequeue may straddle the wrap boundary.
REQ-030 Reads of entry rd_ptr+1 also wrap.
REQ-031 `empty` = occupancy==0; `almost_full` = occupancy>=AFULL_THRESH.
REQ-032 Latency: an entry enqueued at edge N is visible on `inst_*` after edge N (zero bubble); there is no write-to-read bypass within the same cycle.
REQ-033 `flush`=1 at an edge sets wr_ptr=rd_ptr=occupancy=0 and ignores same-cycle enqueue and dequeue.
REQ-034 `flush` does not clear `overflow`.

Reset
REQ-035 `rst_n`=0 at a rising edge sets wr_ptr, rd_ptr and occupancy to 0 and clears `overflow`.
REQ-036 Reset overrides `flush`, enqueue and dequeue in the same cycle, including mid-operation.
REQ-037 After reset: `empty`=1, `enq_ready`=1, `almost_full`=0, `inst_1_valid`=`inst_2_valid`=0.
REQ-038 Storage array contents are not reset.

Verification
REQ-039 Dual enqueue then dual fetch: A=16'h1234, B=16'h5678 both valid for 1 cycle -> next cycle `inst_1_type`=1, `inst_1_dest`=2, `inst_1_src1`=3, `inst_1_src0`=4, `inst_2_type`=5, occupancy=2; both fetches -> occupancy=0, `empty`=1.
REQ-040 Compaction: only `instruction_val_2` with 16'hABCD -> `inst_1_type`=4'hA, `inst_1_valid`=1, `inst_2_valid`=0.
REQ-041 Fill and overflow: fill to 31 entries -> `enq_ready`=0, `almost_full`=1; one more valid -> dropped, occupancy stays 31, `overflow`=1.
REQ-042 Wrap: enqueue and dequeue 2 per cycle for 40 cycles with an incrementing pattern -> every dequeued word matches the enqueue order and occupancy stays constant.
REQ-043 Ordering rule: `inst_2_fetch`=1 with `inst_1_fetch`=0 and occupancy 3 -> occupancy stays 3 and head is unchanged.
REQ-044 Flush/reset mid-stream: occupancy 10, `flush` with a simultaneous dual enqueue -> occupancy=0; `rst_n`=0 with `overflow` set -> `overflow`=0, `empty`=1.

Source files
------------

// File: rtl/dual_issue_iq.sv
// dual_issue_iq -- two-wide in-order instruction queue.
//
// A single circular buffer shared by two enqueue lanes and two dequeue lanes.
// Enqueued words are compacted, so there are never holes in the buffer. The
// head two entries are presented show-ahead, straight from registered storage.
//
// Ports
//   clk, rst_n                    clock, synchronous active-low reset
//   flush                         drop every queued entry
//   instruction_1/_val_1          older enqueue word {type,dest,src1,src0}
//   instruction_2/_val_2          younger enqueue word, same layout
//   enq_ready                     at least two free entries this cycle
//   inst_1_fetch / inst_2_fetch   consumer takes head / head+1
//   inst_1_* / inst_2_*           head / head+1 entry and its valid
//   occupancy                     entries held
//   empty, almost_full, overflow  status; overflow is sticky until reset
module dual_issue_iq #(
  parameter int INS_PART_WID = 4,
  parameter int QUEUE_DEPTH  = 32,
  parameter int AFULL_THRESH = 28,
  localparam int PTR_WIDTH   = $clog2(QUEUE_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [INS_PART_WID*4-1:0] instruction_1,
  input  logic                      instruction_val_1,
  input  logic [INS_PART_WID*4-1:0] instruction_2,
  input  logic                      instruction_val_2,
  output logic                      enq_ready,
  input  logic                      inst_1_fetch,
  input  logic                      inst_2_fetch,
  output logic                      inst_1_valid,
  output logic [INS_PART_WID-1:0]   inst_1_type,
  output logic [INS_PART_WID-1:0]   inst_1_dest,
  output logic [INS_PART_WID-1:0]   inst_1_src0,
  output logic [INS_PART_WID-1:0]   inst_1_src1,
  output logic                      inst_2_valid,
  output logic [INS_PART_WID-1:0]   inst_2_type,
  output logic [INS_PART_WID-1:0]   inst_2_dest,
  output logic [INS_PART_WID-1:0]   inst_2_src0,
  output logic [INS_PART_WID-1:0]   inst_2_src1,
  output logic [PTR_WIDTH:0]        occupancy,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      overflow
);

  localparam int INS_WID = INS_PART_WID * 4;
  localparam int W       = INS_PART_WID;

  typedef logic [PTR_WIDTH-1:0] ptr_t;
  typedef logic [PTR_WIDTH:0]   occ_t;

  logic [INS_WID-1:0] mem_q [QUEUE_DEPTH];

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  occ_t occ_q, occ_d;
  logic overflow_q, overflow_d;

  logic               we0, we1;
  ptr_t               wa0, wa1;
  logic [INS_WID-1:0] wd0, wd1;
  occ_t               n_enq, n_deq;
  ptr_t               rd_ptr_p1;
  logic [INS_WID-1:0] head0, head1;

  // Ready is judged on current occupancy only; a same-cycle dequeue earns no credit.
  assign enq_ready    = (occ_q <= occ_t'(QUEUE_DEPTH - 2));
  assign inst_1_valid = (occ_q >= occ_t'(1));
  assign inst_2_valid = (occ_q >= occ_t'(2));
  assign empty        = (occ_q == '0);
  assign almost_full  = (occ_q >= occ_t'(AFULL_THRESH));
  assign occupancy    = occ_q;
  assign overflow     = overflow_q;

  assign rd_ptr_p1 = rd_ptr_q + ptr_t'(1);
  assign head0     = mem_q[rd_ptr_q];
  assign head1     = mem_q[rd_ptr_p1];

  assign inst_1_type = head0[4*W-1:3*W];
  assign inst_1_dest = head0[3*W-1:2*W];
  assign inst_1_src1 = head0[2*W-1:W];
  assign inst_1_src0 = head0[W-1:0];
  assign inst_2_type = head1[4*W-1:3*W];
  assign inst_2_dest = head1[3*W-1:2*W];
  assign inst_2_src1 = head1[2*W-1:W];
  assign inst_2_src0 = head1[W-1:0];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    occ_d      = occ_q;
    overflow_d = overflow_q;
    we0        = 1'b0;
    we1        = 1'b0;
    wa0        = wr_ptr_q;
    wa1        = wr_ptr_q + ptr_t'(1);
    wd0        = instruction_1;
    wd1        = instruction_2;
    n_enq      = '0;
    n_deq      = '0;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (enq_ready) begin
        if (instruction_val_1 && instruction_val_2) begin
          we0   = 1'b1;
          we1   = 1'b1;
          n_enq = occ_t'(2);
        end else if (instruction_val_1) begin
          we0   = 1'b1;
          n_enq = occ_t'(1);
        end else if (instruction_val_2) begin
          // A lone younger word slides into the older slot so no hole is left.
          we0   = 1'b1;
          wd0   = instruction_2;
          n_enq = occ_t'(1);
        end
      end else if (instruction_val_1 || instruction_val_2) begin
        overflow_d = 1'b1;
      end

      // Lane 2 can only issue alongside lane 1 to keep issue in order.
      if (inst_1_fetch && inst_1_valid) begin
        n_deq = (inst_2_fetch && inst_2_valid) ? occ_t'(2) : occ_t'(1);
      end

      wr_ptr_d = wr_ptr_q + ptr_t'(n_enq);
      rd_ptr_d = rd_ptr_q + ptr_t'(n_deq);
      occ_d    = occ_q + n_enq - n_deq;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage carries no reset; the valid flags alone say what is meaningful.
  always_ff @(posedge clk) begin
    if (we0) mem_q[wa0] <= wd0;
    if (we1) mem_q[wa1] <= wd1;
  end

endmodule

// File: tb/tb_dual_issue_iq.sv
module tb_dual_issue_iq;

  localparam int DEPTH = 32;
  localparam int AF    = 28;

  logic        clk = 1'b0;
  logic        rst_n, flush;
  logic [15:0] instruction_1, instruction_2;
  logic        instruction_val_1, instruction_val_2;
  logic        enq_ready, inst_1_fetch, inst_2_fetch;
  logic        inst_1_valid, inst_2_valid;
  logic [3:0]  inst_1_type, inst_1_dest, inst_1_src0, inst_1_src1;
  logic [3:0]  inst_2_type, inst_2_dest, inst_2_src0, inst_2_src1;
  logic [5:0]  occupancy;
  logic        empty, almost_full, overflow;

  dual_issue_iq #(.INS_PART_WID(4), .QUEUE_DEPTH(DEPTH), .AFULL_THRESH(AF)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .instruction_1(instruction_1), .instruction_val_1(instruction_val_1),
    .instruction_2(instruction_2), .instruction_val_2(instruction_val_2),
    .enq_ready(enq_ready), .inst_1_fetch(inst_1_fetch), .inst_2_fetch(inst_2_fetch),
    .inst_1_valid(inst_1_valid), .inst_1_type(inst_1_type), .inst_1_dest(inst_1_dest),
    .inst_1_src0(inst_1_src0), .inst_1_src1(inst_1_src1),
    .inst_2_valid(inst_2_valid), .inst_2_type(inst_2_type), .inst_2_dest(inst_2_dest),
    .inst_2_src0(inst_2_src0), .inst_2_src1(inst_2_src1),
    .occupancy(occupancy), .empty(empty), .almost_full(almost_full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;

  // Reference model: the queue contents in program order plus the sticky flag.
  logic [15:0] mq[$];
  bit          m_ovf = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int nd;
    if (!rst_n) begin
      mq.delete();
      m_ovf = 0;
    end else if (flush) begin
      mq.delete();
    end else begin
      nd = 0;
      if (inst_1_fetch && mq.size() >= 1) nd = (inst_2_fetch && mq.size() >= 2) ? 2 : 1;
      if (instruction_val_1 || instruction_val_2) begin
        if (DEPTH - mq.size() >= 2) begin
          for (int k = 0; k < nd; k++) void'(mq.pop_front());
          nd = 0;
          if (instruction_val_1) mq.push_back(instruction_1);
          if (instruction_val_2) mq.push_back(instruction_2);
        end else begin
          m_ovf = 1;
        end
      end
      for (int k = 0; k < nd; k++) void'(mq.pop_front());
    end
  endtask

  // Compare process: DUT state against the model every cycle, between edges.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("occupancy", occupancy, mq.size());
      chk("empty", empty, mq.size() == 0);
      chk("enq_ready", enq_ready, (DEPTH - mq.size()) >= 2);
      chk("almost_full", almost_full, mq.size() >= AF);
      chk("overflow", overflow, m_ovf);
      chk("inst_1_valid", inst_1_valid, mq.size() >= 1);
      chk("inst_2_valid", inst_2_valid, mq.size() >= 2);
      if (mq.size() >= 1)
        chk("head0", {inst_1_type, inst_1_dest, inst_1_src1, inst_1_src0}, mq[0]);
      if (mq.size() >= 2)
        chk("head1", {inst_2_type, inst_2_dest, inst_2_src1, inst_2_src0}, mq[1]);
    end
  end

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cyc(input bit v1, input bit v2, input logic [15:0] a, input logic [15:0] b,
                     input bit f1, input bit f2, input bit fl);
    instruction_val_1 = v1; instruction_val_2 = v2;
    instruction_1 = a; instruction_2 = b;
    inst_1_fetch = f1; inst_2_fetch = f2; flush = fl;
    step();
  endtask

  task automatic idle();
    cyc(0, 0, 16'h0, 16'h0, 0, 0, 0);
  endtask

  logic [15:0] seq;

  initial begin
    rst_n = 0;
    idle();
    idle();
    chk_en = 1;
    rst_n = 1;
    chk("rst_empty", empty, 1);
    chk("rst_enq_ready", enq_ready, 1);
    chk("rst_afull", almost_full, 0);
    chk("rst_v1", inst_1_valid, 0);
    chk("rst_v2", inst_2_valid, 0);
    chk("rst_occ", occupancy, 0);

    // Dual enqueue then dual fetch.
    cyc(1, 1, 16'h1234, 16'h5678, 0, 0, 0);
    idle();
    chk("d_type1", inst_1_type, 1);
    chk("d_dest1", inst_1_dest, 2);
    chk("d_src1_1", inst_1_src1, 3);
    chk("d_src0_1", inst_1_src0, 4);
    chk("d_type2", inst_2_type, 5);
    chk("d_occ2", occupancy, 2);
    cyc(0, 0, 16'h0, 16'h0, 1, 1, 0);
    chk("d_occ0", occupancy, 0);
    chk("d_empty", empty, 1);

    // Lone younger word compacts into the head.
    cyc(0, 1, 16'h0, 16'hABCD, 0, 0, 0);
    chk("c_type", inst_1_type, 4'hA);
    chk("c_v1", inst_1_valid, 1);
    chk("c_v2", inst_2_valid, 0);
    cyc(0, 0, 16'h0, 16'h0, 1, 0, 0);

    // Fill to 31 then overflow.
    for (int i = 0; i < 15; i++) cyc(1, 1, 16'(2 * i), 16'(2 * i + 1), 0, 0, 0);
    cyc(1, 0, 16'h0BAD, 16'h0, 0, 0, 0);
    chk("f_occ31", occupancy, 31);
    chk("f_ready", enq_ready, 0);
    chk("f_afull", almost_full, 1);
    cyc(1, 0, 16'hDEAD, 16'h0, 0, 0, 0);
    chk("f_occ_hold", occupancy, 31);
    chk("f_ovf", overflow, 1);

    // Reset with overflow set.
    rst_n = 0;
    cyc(1, 1, 16'h1111, 16'h2222, 1, 1, 1);
    rst_n = 1;
    chk("r_ovf", overflow, 0);
    chk("r_empty", empty, 1);

    // Flush at occupancy 10 with a simultaneous dual enqueue.
    for (int i = 0; i < 5; i++) cyc(1, 1, 16'h3000 + 16'(i), 16'h4000 + 16'(i), 0, 0, 0);
    chk("fl_occ10", occupancy, 10);
    cyc(1, 1, 16'h7777, 16'h8888, 0, 0, 1);
    chk("fl_occ0", occupancy, 0);

    // Lane 2 fetch alone is ignored.
    cyc(1, 1, 16'h9123, 16'h9456, 0, 0, 0);
    cyc(1, 0, 16'h9789, 16'h0, 0, 0, 0);
    cyc(0, 0, 16'h0, 16'h0, 0, 1, 0);
    chk("o_occ3", occupancy, 3);
    chk("o_head", {inst_1_type, inst_1_dest, inst_1_src1, inst_1_src0}, 16'h9123);

    // Steady two-in/two-out across the wrap boundary.
    cyc(0, 0, 16'h0, 16'h0, 0, 0, 1);
    seq = 16'h0;
    cyc(1, 1, seq, seq + 16'd1, 0, 0, 0);
    seq = seq + 16'd2;
    cyc(1, 1, seq, seq + 16'd1, 0, 0, 0);
    seq = seq + 16'd2;
    for (int i = 0; i < 40; i++) begin
      cyc(1, 1, seq, seq + 16'd1, 1, 1, 0);
      seq = seq + 16'd2;
      chk("w_occ", occupancy, 4);
      chk("w_head", {inst_1_type, inst_1_dest, inst_1_src1, inst_1_src0}, seq - 16'd4);
    end

    // Randomized traffic, alternating fill-heavy and drain-heavy phases.
    for (int i = 0; i < 3000; i++) begin
      bit heavy;
      heavy = ((i / 150) % 2) == 0;
      rst_n = ($urandom_range(0, 299) != 0);
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
          16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
          heavy ? 1'($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 1)),
          1'($urandom_range(0, 99) == 0));
    end
    rst_n = 1;
    idle();
    @(negedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
